// File: rtl/kronos_arb_pkg.sv
// kronos_arb_pkg: shared types and constants for the Kronos unified-memory arbiter.
package kronos_arb_pkg;
   typedef enum logic [1:0] {OWN_NONE, OWN_INSTR, OWN_DATA} owner_e;
   localparam int unsigned STARVE_CNT_W = 4;
   typedef logic [31:0] addr_t;
   typedef logic [31:0] data_t;
   typedef logic [31:0] strb_t;
endpackage

// File: rtl/kronos_arb_starve_ctr.sv
// kronos_arb_starve_ctr: counts consecutive cycles a pending fetch loses to data, saturating at MaxStarve.
module kronos_arb_starve_ctr
   import kronos_arb_pkg::*;
#(
   parameter int unsigned MaxStarve = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic instr_req_i,
   input  logic instr_gnt_i,
   input  logic data_gnt_i,
   output logic force_instr_o
);
   localparam logic [STARVE_CNT_W-1:0] Max = STARVE_CNT_W'(MaxStarve);
   logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;
   always_comb begin
      cnt_d = (!instr_req_i || instr_gnt_i) ? '0 :
              (data_gnt_i && cnt_q != Max) ? cnt_q + 1'b1 : cnt_q;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
   assign force_instr_o = (cnt_q == Max);
endmodule

// File: rtl/kronos_mem_arbiter.sv
// kronos_mem_arbiter: data-priority arbiter sharing one SRAM between fetch and load/store ports.
// Optional grant/stall statistics counters enabled by KRONOS_MEM_ARB_STATS_EN.
module kronos_mem_arbiter
   import kronos_arb_pkg::*;
#(
   parameter int unsigned MaxStarve = 4,
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 instr_req_i,
   output logic                 instr_gnt_o,
   input  logic [AddrWidth-1:0] instr_addr_i,
   output logic                 instr_rvalid_o,
   output logic [DataWidth-1:0] instr_rdata_o,
   input  logic                 data_req_i,
   output logic                 data_gnt_o,
   input  logic [AddrWidth-1:0] data_addr_i,
   input  logic                 data_we_i,
   input  logic [DataWidth-1:0] data_wdata_i,
   input  logic [DataWidth-1:0] data_strb_i,
   output logic                 data_rvalid_o,
   output logic [DataWidth-1:0] data_rdata_o,
   output logic                 mem_req_o,
   output logic [AddrWidth-1:0] mem_addr_o,
   output logic                 mem_we_o,
   output logic [DataWidth-1:0] mem_wdata_o,
   output logic [DataWidth-1:0] mem_strb_o,
   input  logic [DataWidth-1:0] mem_rdata_i
`ifdef KRONOS_MEM_ARB_STATS_EN
   ,
   output logic [31:0]          stat_instr_grants_o,
   output logic [31:0]          stat_data_grants_o,
   output logic [31:0]          stat_instr_stalls_o
`endif
);
   owner_e owner_q, owner_d;
   logic force_instr;

   kronos_arb_starve_ctr #(.MaxStarve(MaxStarve)) u_starve (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .instr_req_i  (instr_req_i),
      .instr_gnt_i  (instr_gnt_o),
      .data_gnt_i   (data_gnt_o),
      .force_instr_o(force_instr)
   );

   always_comb begin
      instr_gnt_o = !rst_i && instr_req_i && (!data_req_i || force_instr);
      data_gnt_o  = !rst_i && data_req_i && !(instr_req_i && force_instr);
      mem_req_o   = instr_gnt_o || data_gnt_o;
      mem_addr_o  = data_gnt_o ? data_addr_i : instr_gnt_o ? instr_addr_i : '0;
      mem_we_o    = data_gnt_o && data_we_i;
      mem_wdata_o = data_gnt_o ? data_wdata_i : '0;
      mem_strb_o  = data_gnt_o ? data_strb_i : '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) owner_q <= OWN_NONE;
      else owner_q <= owner_d;
   end

   always_comb begin
      owner_d = data_gnt_o ? OWN_DATA : instr_gnt_o ? OWN_INSTR : OWN_NONE;
   end

   // Gating on rst_i drops a response whose grant preceded the reset cycle.
   always_comb begin
      instr_rvalid_o = !rst_i && owner_q == OWN_INSTR;
      data_rvalid_o  = !rst_i && owner_q == OWN_DATA;
      instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
      data_rdata_o   = data_rvalid_o ? mem_rdata_i : '0;
   end

`ifdef KRONOS_MEM_ARB_STATS_EN
   logic [31:0] ig_q, ig_d, dg_q, dg_d, st_q, st_d;
   always_comb begin
      ig_d = ig_q + 32'(instr_gnt_o);
      dg_d = dg_q + 32'(data_gnt_o);
      st_d = st_q + 32'(instr_req_i && !instr_gnt_o);
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ig_q <= '0;
         dg_q <= '0;
         st_q <= '0;
      end else begin
         ig_q <= ig_d;
         dg_q <= dg_d;
         st_q <= st_d;
      end
   end
   assign stat_instr_grants_o = ig_q;
   assign stat_data_grants_o  = dg_q;
   assign stat_instr_stalls_o = st_q;
`endif
endmodule

// File: tb/tb_kronos_mem_arbiter.sv
// tb_kronos_mem_arbiter: directed self-checking bench for kronos_mem_arbiter (MaxStarve=4).
module tb_kronos_mem_arbiter;
   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        instr_req_i, instr_gnt_o, instr_rvalid_o;
   logic [31:0] instr_addr_i, instr_rdata_o;
   logic        data_req_i, data_gnt_o, data_we_i, data_rvalid_o;
   logic [31:0] data_addr_i, data_wdata_i, data_strb_i, data_rdata_o;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_strb_o, mem_rdata_i;
`ifdef KRONOS_MEM_ARB_STATS_EN
   logic [31:0] stat_instr_grants_o, stat_data_grants_o, stat_instr_stalls_o;
`endif
   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   kronos_mem_arbiter #(.MaxStarve(4)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .instr_req_i   (instr_req_i),
      .instr_gnt_o   (instr_gnt_o),
      .instr_addr_i  (instr_addr_i),
      .instr_rvalid_o(instr_rvalid_o),
      .instr_rdata_o (instr_rdata_o),
      .data_req_i    (data_req_i),
      .data_gnt_o    (data_gnt_o),
      .data_addr_i   (data_addr_i),
      .data_we_i     (data_we_i),
      .data_wdata_i  (data_wdata_i),
      .data_strb_i   (data_strb_i),
      .data_rvalid_o (data_rvalid_o),
      .data_rdata_o  (data_rdata_o),
      .mem_req_o     (mem_req_o),
      .mem_addr_o    (mem_addr_o),
      .mem_we_o      (mem_we_o),
      .mem_wdata_o   (mem_wdata_o),
      .mem_strb_o    (mem_strb_o),
      .mem_rdata_i   (mem_rdata_i)
`ifdef KRONOS_MEM_ARB_STATS_EN
      ,
      .stat_instr_grants_o(stat_instr_grants_o),
      .stat_data_grants_o (stat_data_grants_o),
      .stat_instr_stalls_o(stat_instr_stalls_o)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Expected D,D,D,D,I grants with both ports requesting, rvalid one cycle behind.
   task automatic run_pattern(input int n, input string tag);
      for (int k = 0; k < n; k++) begin
         mem_rdata_i = 32'hA000_0000 + 32'(k);
         @(negedge clk_i);
         chk({tag, "_ignt"}, 32'(instr_gnt_o), 32'(k % 5 == 4));
         chk({tag, "_dgnt"}, 32'(data_gnt_o), 32'(k % 5 != 4));
         chk({tag, "_irv"}, 32'(instr_rvalid_o), 32'(k > 0 && (k - 1) % 5 == 4));
         chk({tag, "_drv"}, 32'(data_rvalid_o), 32'(k > 0 && (k - 1) % 5 != 4));
         chk({tag, "_drd"}, data_rdata_o, (k > 0 && (k - 1) % 5 != 4) ? mem_rdata_i : 32'h0);
         tick();
      end
   endtask

   initial begin
      rst_i = 1'b1;
      instr_req_i = 1'b1;
      data_req_i = 1'b1;
      instr_addr_i = 32'h8000_0000;
      data_addr_i = 32'h8000_0100;
      data_we_i = 1'b0;
      data_wdata_i = 32'h0;
      data_strb_i = 32'h0;
      mem_rdata_i = 32'hCAFE_F00D;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i);
         chk("rst_ignt", 32'(instr_gnt_o), 32'h0);
         chk("rst_dgnt", 32'(data_gnt_o), 32'h0);
         chk("rst_mreq", 32'(mem_req_o), 32'h0);
         chk("rst_irv", 32'(instr_rvalid_o), 32'h0);
         chk("rst_drv", 32'(data_rvalid_o), 32'h0);
         chk("rst_rd", instr_rdata_o | data_rdata_o, 32'h0);
         tick();
      end
      rst_i = 1'b0;
      run_pattern(10, "pat");
`ifdef KRONOS_MEM_ARB_STATS_EN
      chk("stat_dg", stat_data_grants_o, 32'd8);
      chk("stat_ig", stat_instr_grants_o, 32'd2);
      chk("stat_st", stat_instr_stalls_o, 32'd8);
`endif
      instr_req_i = 1'b0;
      data_req_i = 1'b0;
      mem_rdata_i = 32'h0BAD_0001;
      @(negedge clk_i);
      chk("idle_mreq", 32'(mem_req_o), 32'h0);
      chk("idle_addr", mem_addr_o, 32'h0);
      chk("idle_irv", 32'(instr_rvalid_o), 32'h1);
      chk("idle_ird", instr_rdata_o, 32'h0BAD_0001);
      chk("idle_drv", 32'(data_rvalid_o), 32'h0);
      tick();
      instr_req_i = 1'b1;
      instr_addr_i = 32'h8000_0010;
      @(negedge clk_i);
      chk("ird_gnt", 32'(instr_gnt_o), 32'h1);
      chk("ird_dgnt", 32'(data_gnt_o), 32'h0);
      chk("ird_addr", mem_addr_o, 32'h8000_0010);
      chk("ird_we", 32'(mem_we_o), 32'h0);
      chk("ird_strb", mem_strb_o, 32'h0);
      tick();
      instr_req_i = 1'b0;
      mem_rdata_i = 32'hDEAD_BEEF;
      @(negedge clk_i);
      chk("ird_rv", 32'(instr_rvalid_o), 32'h1);
      chk("ird_rd", instr_rdata_o, 32'hDEAD_BEEF);
      chk("ird_drv", 32'(data_rvalid_o), 32'h0);
      chk("ird_drd", data_rdata_o, 32'h0);
      tick();
      data_req_i = 1'b1;
      data_we_i = 1'b1;
      data_addr_i = 32'h8000_1000;
      data_wdata_i = 32'h1234_5678;
      data_strb_i = 32'h0000_FFFF;
      @(negedge clk_i);
      chk("wr_gnt", 32'(data_gnt_o), 32'h1);
      chk("wr_addr", mem_addr_o, 32'h8000_1000);
      chk("wr_we", 32'(mem_we_o), 32'h1);
      chk("wr_wdata", mem_wdata_o, 32'h1234_5678);
      chk("wr_strb", mem_strb_o, 32'h0000_FFFF);
      tick();
      data_req_i = 1'b0;
      data_we_i = 1'b0;
      mem_rdata_i = 32'h0000_0055;
      @(negedge clk_i);
      chk("wr_rv", 32'(data_rvalid_o), 32'h1);
      chk("wr_rd", data_rdata_o, 32'h0000_0055);
      chk("wr_irv", 32'(instr_rvalid_o), 32'h0);
      tick();
      instr_req_i = 1'b1;
      data_req_i = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk_i);
         chk("pre_dgnt", 32'(data_gnt_o), 32'h1);
         tick();
      end
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("drop_rv", 32'(data_rvalid_o), 32'h0);
      chk("drop_rd", data_rdata_o, 32'h0);
      chk("drop_gnt", 32'(data_gnt_o | instr_gnt_o), 32'h0);
      tick();
      rst_i = 1'b0;
      run_pattern(5, "post");
      instr_req_i = 1'b0;
      data_req_i = 1'b0;
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
